// File: rtl/ko_sequencer.sv
// ko_sequencer: KO banner overlay sequencer (slide, blink, hold, wait).
// Define KO_SLIDE_EN to build the slide-in of the banner from START_Y.
module ko_sequencer #(
  parameter logic [9:0] FINAL_X      = 10'd180,
  parameter logic [9:0] FINAL_Y      = 10'd80,
  parameter logic [9:0] START_Y      = 10'd0,
  parameter logic [9:0] SLIDE_STEP   = 10'd8,
  parameter logic [7:0] BLINK_FRAMES = 8'd8,
  parameter logic [7:0] BLINK_COUNT  = 8'd3,
  parameter logic [7:0] HOLD_FRAMES  = 8'd120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       ko_trigger,
  input  logic       restart,
  output logic       exist_ko,
  output logic [9:0] ko_x,
  output logic [9:0] ko_y,
  output logic       busy,
  output logic       round_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLIDE = 3'd1,
    BLINK = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } st_e;

  st_e        st;
  logic       s0;
  logic       s1;
  logic       tick;
  logic [7:0] frm_cnt;
  logic [7:0] blk_cnt;

`ifdef KO_SLIDE_EN
  localparam logic [9:0] Y_RST = START_Y;
  localparam st_e        ST_GO = SLIDE;

  logic [10:0] y_sum;
  assign y_sum = {1'b0, ko_y} + {1'b0, SLIDE_STEP};
`else
  localparam logic [9:0] Y_RST = FINAL_Y;
  localparam st_e        ST_GO = BLINK;

  logic unused_cfg;
  assign unused_cfg = ^{START_Y, SLIDE_STEP};
`endif

  assign tick  = s0 & ~s1;
  assign state = st;

  always_ff @(posedge Clk) begin
    ko_x       <= FINAL_X;
    round_done <= 1'b0;
    if (Reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= frame_clk;
      s1 <= s0;
    end
    // restart shares the reset path and wins over trigger and tick
    if (Reset || restart) begin
      st       <= IDLE;
      exist_ko <= 1'b0;
      busy     <= 1'b0;
      ko_y     <= Y_RST;
      frm_cnt  <= 8'd0;
      blk_cnt  <= 8'd0;
    end else begin
      unique case (st)
        IDLE: if (ko_trigger) begin
          st       <= ST_GO;
          exist_ko <= 1'b1;
          busy     <= 1'b1;
          ko_y     <= Y_RST;
          frm_cnt  <= 8'd0;
          blk_cnt  <= 8'd0;
        end
`ifdef KO_SLIDE_EN
        SLIDE: if (tick) begin
          if (y_sum >= {1'b0, FINAL_Y}) begin
            ko_y    <= FINAL_Y;
            st      <= BLINK;
            frm_cnt <= 8'd0;
            blk_cnt <= 8'd0;
          end else begin
            ko_y <= y_sum[9:0];
          end
        end
`endif
        BLINK: if (tick) begin
          if (frm_cnt == BLINK_FRAMES - 8'd1) begin
            frm_cnt <= 8'd0;
            if (exist_ko) begin
              exist_ko <= 1'b0;
            end else if (blk_cnt == BLINK_COUNT - 8'd1) begin
              exist_ko <= 1'b1;
              blk_cnt  <= 8'd0;
              st       <= HOLD;
            end else begin
              exist_ko <= 1'b1;
              blk_cnt  <= blk_cnt + 8'd1;
            end
          end else begin
            frm_cnt <= frm_cnt + 8'd1;
          end
        end
        HOLD: if (tick) begin
          if (frm_cnt == HOLD_FRAMES - 8'd1) begin
            frm_cnt    <= 8'd0;
            st         <= WAIT;
            busy       <= 1'b0;
            round_done <= 1'b1;
          end else begin
            frm_cnt <= frm_cnt + 8'd1;
          end
        end
        WAIT: st <= WAIT;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ko_sequencer.sv
// tb_ko_sequencer: random frame/trigger/restart stimulus vs frame-count model.
// Works with and without KO_SLIDE_EN defined.
module tb_ko_sequencer;

  localparam int FX   = 180;
  localparam int FY   = 80;
  localparam int SY   = 0;
  localparam int STEP = 8;
  localparam int BF   = 8;
  localparam int BC   = 3;
  localparam int HF   = 120;
`ifdef KO_SLIDE_EN
  localparam int NS   = (FY - SY + STEP - 1) / STEP;
  localparam int YR   = SY;
`else
  localparam int NS   = 0;
  localparam int YR   = FY;
`endif
  localparam int NB   = 2 * BC * BF;
  localparam int NE   = NS + NB + HF;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       ko_trigger;
  logic       restart;
  logic       exist_ko;
  logic [9:0] ko_x;
  logic [9:0] ko_y;
  logic       busy;
  logic       round_done;
  logic [2:0] state;

  ko_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .ko_trigger(ko_trigger),
    .restart   (restart),
    .exist_ko  (exist_ko),
    .ko_x      (ko_x),
    .ko_y      (ko_y),
    .busy      (busy),
    .round_done(round_done),
    .state     (state)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // model: ticks counted since trigger decide everything
  bit mv  = 0;
  bit run = 0;
  bit fin = 0;
  bit rd  = 0;
  bit p1  = 0;
  bit p2  = 0;
  bit tk  = 0;
  int n   = 0;

  always @(posedge Clk) begin
    rd = 0;
    tk = p1 & ~p2;
    if (Reset) begin
      run = 0; fin = 0; n = 0;
      p1 = 0; p2 = 0; mv = 1;
    end else begin
      p2 = p1;
      p1 = frame_clk;
      if (restart) begin
        run = 0; fin = 0;
      end else if (!run && !fin) begin
        if (ko_trigger) begin
          run = 1; n = 0;
        end
      end else if (run && tk) begin
        n++;
        if (n == NE) begin
          run = 0; fin = 1; rd = 1;
        end
      end
    end
  end

  int es, ee, eb, ey;

  always @(negedge Clk) if (mv) begin
    if (fin) begin
      es = 4; ee = 1; eb = 0; ey = FY;
    end else if (!run) begin
      es = 0; ee = 0; eb = 0; ey = YR;
    end else if (n < NS) begin
      es = 1; ee = 1; eb = 1;
      ey = SY + n * STEP;
      if (ey > FY) ey = FY;
    end else if (n < NS + NB) begin
      es = 2; eb = 1; ey = FY;
      ee = (((n - NS) / BF) % 2 == 0) ? 1 : 0;
    end else begin
      es = 3; ee = 1; eb = 1; ey = FY;
    end
    chk("state", state, es);
    chk("exist_ko", exist_ko, ee);
    chk("busy", busy, eb);
    chk("ko_y", ko_y, ey);
    chk("ko_x", ko_x, FX);
    chk("round_done", round_done, rd);
  end

  task automatic pulse(input int hi, input int lo);
    frame_clk = 1'b1;
    repeat (hi) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (lo) @(posedge Clk);
    #1;
  endtask

  task automatic rnd_pulse();
    pulse($urandom_range(1, 6), $urandom_range(1, 6));
  endtask

  task automatic trig();
    ko_trigger = 1'b1;
    @(posedge Clk);
    #1 ko_trigger = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge Clk);
    #1 restart = 1'b0;
  endtask

  initial begin
    bit hit;
    Reset = 1'b1;
    frame_clk = 1'b0;
    ko_trigger = 1'b0;
    restart = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    // full sequence, plus extra frames in WAIT
    trig();
    repeat (NE + 20) rnd_pulse();
    chk("reach_wait", fin, 1);

    // restart together with a tick while hidden in BLINK
    do_restart();
    trig();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (run && n == NS + BF) hit = 1;
      else rnd_pulse();
    end
    chk("reach_hidden", hit, 1);
    frame_clk = 1'b1;
    @(posedge Clk);
    #1 restart = 1'b1;
    @(posedge Clk);
    #1 restart = 1'b0;
    frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // long frame_clk high, trigger held through WAIT
    ko_trigger = 1'b1;
    repeat (2) rnd_pulse();
    frame_clk = 1'b1;
    repeat (1000) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("one_tick", n, 3);
    repeat (NE + 10) rnd_pulse();
    chk("held_trig_wait", fin, 1);
    ko_trigger = 1'b0;

    // random mix
    for (int i = 0; i < 1500; i++) begin
      ko_trigger = ($urandom_range(0, 3) == 0);
      restart = ($urandom_range(0, 299) == 0);
      rnd_pulse();
    end
    restart = 1'b0;
    ko_trigger = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
